// File: rtl/evt_pkg.sv
// Shared definitions for the event trigger generator: state encoding and default field width.
package evt_pkg;

    localparam int DEF_CNT_W = 8;

    typedef logic [1:0] evt_state_t;

    localparam evt_state_t ST_IDLE = 2'd0;
    localparam evt_state_t ST_WAIT = 2'd1;
    localparam evt_state_t ST_HOLD = 2'd2;
    localparam evt_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/evt_timer.sv
// Reloadable down-counter: load has priority, decrement stops at zero so the value never wraps.
module evt_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/event_trig_gen.sv
// Periodic burst trigger generator with busy back-pressure and abort.
// Optional stall counter enabled by defining EVENT_TRIG_GEN_STALL_CNT_EN.
module event_trig_gen
    import evt_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_period,
    input  logic [CNT_W-1:0] req_count,
    input  logic             abort,
    input  logic             busy,
    output logic             trig,
    output logic             done,
    output logic [CNT_W-1:0] stall_cnt
);

    evt_state_t       state;
    evt_state_t       state_nxt;
    logic [CNT_W-1:0] period_m1;
    logic [CNT_W-1:0] req_period_m1;
    logic [CNT_W-1:0] count_rem;
    logic             timer_zero;
    logic             accept;
    logic             due;
    logic             fire;
    logic             last_fire;
    logic             enter_hold;

    // A zero period behaves like a period of one, so the reload value saturates at 0.
    assign req_period_m1 = (req_period == '0) ? '0 : req_period - CNT_W'(1);

    assign req_ready  = (state == ST_IDLE);
    assign done       = (state == ST_DONE);
    assign accept     = req_valid && req_ready;
    assign due        = ((state == ST_WAIT) && timer_zero) || (state == ST_HOLD);
    assign fire       = due && !busy && !abort;
    assign last_fire  = fire && (count_rem == CNT_W'(1));
    assign enter_hold = (state == ST_WAIT) && timer_zero && busy && !abort;
    assign trig       = fire;

    evt_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept || fire),
        .load_val (accept ? req_period_m1 : period_m1),
        .dec      (state == ST_WAIT),
        .zero     (timer_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (req_count == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT, ST_HOLD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (enter_hold) begin
                    state_nxt = ST_HOLD;
                end else if (fire) begin
                    state_nxt = last_fire ? ST_DONE : ST_WAIT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            period_m1 <= '0;
            count_rem <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                period_m1 <= req_period_m1;
                count_rem <= req_count;
            end else if (fire) begin
                count_rem <= count_rem - CNT_W'(1);
            end
        end
    end

`ifdef EVENT_TRIG_GEN_STALL_CNT_EN
    // Counts deferrals, not HOLD cycles; sticks at all-ones until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (enter_hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_event_trig_gen.sv
// Directed self-checking bench for event_trig_gen; cycle 0 is the cycle the request is presented.
module tb_event_trig_gen;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_period;
    logic [CNT_W-1:0] req_count;
    logic             abort;
    logic             busy;
    logic             trig;
    logic             done;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int fails  = 0;

`ifdef EVENT_TRIG_GEN_STALL_CNT_EN
    localparam logic [CNT_W-1:0] EXP_STALL = 8'd1;
`else
    localparam logic [CNT_W-1:0] EXP_STALL = 8'd0;
`endif

    event_trig_gen #(
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_period (req_period),
        .req_count  (req_count),
        .abort      (abort),
        .busy       (busy),
        .trig       (trig),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Runs cycles 0..n of one burst; bit k of each mask gives the input or expected output in cycle k.
    task automatic applyStimulus(input string name, input logic [CNT_W-1:0] period,
                                 input logic [CNT_W-1:0] count, input logic [31:0] busy_m,
                                 input logic [31:0] abort_m, input logic [31:0] trig_m,
                                 input logic [31:0] done_m, input logic [31:0] ready_m, input int n);
        for (int k = 0; k <= n; k++) begin
            req_valid  = (k == 0);
            req_period = period;
            req_count  = count;
            busy       = busy_m[k];
            abort      = abort_m[k];
            @(negedge clk);
            checkOutput($sformatf("%s c%0d trig", name, k), {31'b0, trig}, {31'b0, trig_m[k]});
            checkOutput($sformatf("%s c%0d done", name, k), {31'b0, done}, {31'b0, done_m[k]});
            checkOutput($sformatf("%s c%0d ready", name, k), {31'b0, req_ready}, {31'b0, ready_m[k]});
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        busy      = 1'b0;
        abort     = 1'b0;
    endtask

    initial begin
        int ntrig;
        int done_cyc;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_period = '0;
        req_count  = '0;
        abort      = 1'b0;
        busy       = 1'b0;
        #1;
        checkOutput("reset ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset trig", {31'b0, trig}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset stall", {24'b0, stall_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus("p3c2", 8'd3, 8'd2, 32'h0, 32'h0, 32'h48, 32'h80, 32'h101, 8);
        applyStimulus("p0c3", 8'd0, 8'd3, 32'h0, 32'h0, 32'h0E, 32'h10, 32'h21, 5);
        applyStimulus("c0", 8'd5, 8'd0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h5, 2);
        applyStimulus("busy", 8'd2, 8'd2, 32'h1C, 32'h0, 32'hA0, 32'h100, 32'h201, 9);
        checkOutput("busy stall_cnt", {24'b0, stall_cnt}, {24'b0, EXP_STALL});
        applyStimulus("abort", 8'd3, 8'd2, 32'h0, 32'h8, 32'h0, 32'h0, 32'h31, 5);
        applyStimulus("abort idle/done", 8'd1, 8'd1, 32'h0, 32'h5, 32'h2, 32'h4, 32'h9, 3);

        // Maximum count with period 1: 255 triggers in cycles 1..255, done in cycle 256.
        req_valid  = 1'b1;
        req_period = 8'd0;
        req_count  = 8'd255;
        @(negedge clk);
        checkOutput("max ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ntrig     = 0;
        done_cyc  = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (trig) ntrig++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("max trig count", ntrig, 32'd255);
        checkOutput("max done cycle", done_cyc, 32'd256);
        @(posedge clk);
        #1;
        checkOutput("max ready after", {31'b0, req_ready}, 32'd1);

        // Asynchronous reset while a trigger is being presented.
        req_valid  = 1'b1;
        req_period = 8'd3;
        req_count  = 8'd2;
        repeat (3) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
        #1;
        checkOutput("pre-reset trig", {31'b0, trig}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async trig", {31'b0, trig}, 32'd0);
        checkOutput("async ready", {31'b0, req_ready}, 32'd1);
        checkOutput("async done", {31'b0, done}, 32'd0);
        checkOutput("async stall", {24'b0, stall_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("post-reset", 8'd3, 8'd2, 32'h0, 32'h0, 32'h48, 32'h80, 32'h101, 8);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
